// File: rtl/conv_stream_tx_if.sv
// conv_stream_tx_if: configuration, launch, serial stream and result signals
// shared between a host (master) and the conv_stream_tx streamer (slave).
interface conv_stream_tx_if;
  logic        cfg_we;
  logic [6:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic        start;
  logic        filter_valid;
  logic        image_valid;
  logic [3:0]  in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        res_valid;
  logic [3:0]  res_idx;
  logic [15:0] res_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, out_valid, out_data,
    input  filter_valid, image_valid, in_data, res_valid, res_idx, res_data,
           busy, done, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, out_valid, out_data,
    output filter_valid, image_valid, in_data, res_valid, res_idx, res_data,
           busy, done, err
  );
endinterface

// File: rtl/conv_stream_tx.sv
// conv_stream_tx: holds 10 filter taps and 64 image pixels (4-bit each),
// streams them serially to a convolution engine on start, then collects
// 16 results and forwards each with its index.
// Optional feature macro: CONV_STREAM_TX_TIMEOUT_EN -- abort with an err
// pulse after 32 result-less cycles in WAIT; when undefined WAIT waits
// forever and err stays 0.
module conv_stream_tx (
  input  logic           clk,
  input  logic           rst_n,
  conv_stream_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FILT, IMG, WAIT, COLL} state_t;

  state_t      state;
  logic [3:0]  mem [0:73];
  logic [6:0]  cnt;
  logic [3:0]  rcnt;
  logic        fv_q;
  logic        iv_q;
  logic [3:0]  in_data_q;
  logic        busy_q;
  logic        done_q;
  logic        res_vld_p1;
  logic [3:0]  res_idx_p1;
  logic [15:0] res_data_p1;
`ifdef CONV_STREAM_TX_TIMEOUT_EN
  logic [4:0]  tcnt;
  logic        err_q;
`endif

  // Tap/pixel buffer: writable only while idle; reset clears it so a run
  // after reset without reload streams zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 74; i++) mem[i] <= '0;
    end else if (bus.cfg_we && !busy_q && (bus.cfg_addr <= 7'd73)) begin
      mem[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // Sequencer: streams taps then pixels back to back, then gathers results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      fv_q        <= 1'b0;
      iv_q        <= 1'b0;
      in_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_vld_p1  <= 1'b0;
      res_idx_p1  <= '0;
      res_data_p1 <= '0;
`ifdef CONV_STREAM_TX_TIMEOUT_EN
      tcnt        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      res_vld_p1 <= 1'b0;
`ifdef CONV_STREAM_TX_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // A start landing on the done beat belongs to the finished run.
          if (bus.start && !done_q) begin
            state     <= FILT;
            fv_q      <= 1'b1;
            in_data_q <= mem[0];
            cnt       <= 7'd1;
            rcnt      <= '0;
            busy_q    <= 1'b1;
          end
        end
        FILT: begin
          in_data_q <= mem[cnt];
          cnt       <= cnt + 7'd1;
          if (cnt == 7'd10) begin
            fv_q  <= 1'b0;
            iv_q  <= 1'b1;
            state <= IMG;
          end
        end
        IMG: begin
          if (cnt == 7'd74) begin
            iv_q      <= 1'b0;
            in_data_q <= '0;
            state     <= WAIT;
`ifdef CONV_STREAM_TX_TIMEOUT_EN
            tcnt      <= '0;
`endif
          end else begin
            in_data_q <= mem[cnt];
            cnt       <= cnt + 7'd1;
          end
        end
        WAIT, COLL: begin
          if (bus.out_valid) begin
            // Result stage p1: one-cycle forward of the engine result.
            res_vld_p1  <= 1'b1;
            res_data_p1 <= bus.out_data;
            res_idx_p1  <= rcnt;
            state       <= COLL;
            if (rcnt == 4'd15) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              rcnt   <= '0;
              state  <= IDLE;
            end else begin
              rcnt <= rcnt + 4'd1;
            end
          end
`ifdef CONV_STREAM_TX_TIMEOUT_EN
          else if (state == WAIT) begin
            if (tcnt == 5'd31) begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              tcnt <= tcnt + 5'd1;
            end
          end
`endif
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.filter_valid = fv_q;
  assign bus.image_valid  = iv_q;
  assign bus.in_data      = in_data_q;
  assign bus.res_valid    = res_vld_p1;
  assign bus.res_idx      = res_idx_p1;
  assign bus.res_data     = res_data_p1;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
`ifdef CONV_STREAM_TX_TIMEOUT_EN
  assign bus.err          = err_q;
`else
  assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_conv_stream_tx.sv
// tb_conv_stream_tx: directed bench for conv_stream_tx covering reset,
// streaming order, result forwarding with and without gaps, start/cfg
// blocking, asynchronous abort and the WAIT timeout option
// (CONV_STREAM_TX_TIMEOUT_EN).
module tb_conv_stream_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  conv_stream_tx_if bus ();

  conv_stream_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [3:0] exp_mem [74];
  bit         poke = 1'b0;
  int         lost;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string pfx);
    check({pfx, "_fv"},    32'(bus.filter_valid), 0);
    check({pfx, "_iv"},    32'(bus.image_valid),  0);
    check({pfx, "_data"},  32'(bus.in_data),      0);
    check({pfx, "_busy"},  32'(bus.busy),         0);
    check({pfx, "_rv"},    32'(bus.res_valid),    0);
    check({pfx, "_ridx"},  32'(bus.res_idx),      0);
    check({pfx, "_rdata"}, 32'(bus.res_data),     0);
    check({pfx, "_done"},  32'(bus.done),         0);
    check({pfx, "_err"},   32'(bus.err),          0);
  endtask

  // Launch and check every stream beat; returns early after beat stop_at.
  task automatic stream(input int stop_at);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 74; k++) begin
      check($sformatf("fv_%0d", k),   32'(bus.filter_valid), (k < 10) ? 1 : 0);
      check($sformatf("iv_%0d", k),   32'(bus.image_valid),  (k >= 10) ? 1 : 0);
      check($sformatf("data_%0d", k), 32'(bus.in_data),      32'(exp_mem[k]));
      check($sformatf("busy_%0d", k), 32'(bus.busy),         1);
      check($sformatf("rv_%0d", k),   32'(bus.res_valid),    0);
      if (k == stop_at) return;
      bus.out_valid = (k >= 5 && k < 9);
      bus.out_data  = 16'hDEAD;
      bus.cfg_we    = poke && (k == 20);
      bus.cfg_addr  = 7'd3;
      bus.cfg_data  = 4'hF;
      step();
    end
    bus.out_valid = 1'b0;
    bus.cfg_we    = 1'b0;
    check("wait_fv",   32'(bus.filter_valid), 0);
    check("wait_iv",   32'(bus.image_valid),  0);
    check("wait_data", 32'(bus.in_data),      0);
    check("wait_busy", 32'(bus.busy),         1);
  endtask

  // Feed 16 results; optional 3-cycle hole before result gap_at.
  task automatic results(input int gap_at);
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          bus.out_valid = 1'b0;
          step();
          check($sformatf("gap_rv_%0d", g),   32'(bus.res_valid), 0);
          check($sformatf("gap_busy_%0d", g), 32'(bus.busy),      1);
        end
      end
      bus.out_valid = 1'b1;
      bus.out_data  = 16'h0100 + 16'(i);
      step();
      bus.out_valid = 1'b0;
      check($sformatf("rv_%0d", i),    32'(bus.res_valid), 1);
      check($sformatf("ridx_%0d", i),  32'(bus.res_idx),   32'(i));
      check($sformatf("rdata_%0d", i), 32'(bus.res_data),  32'h0100 + 32'(i));
      check($sformatf("done_%0d", i),  32'(bus.done),      (i == 15) ? 1 : 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.start     = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;

    repeat (2) step();
    check_cleared("rst");
    rst_n = 1'b1;
    step();

    // Load taps 1..10 and all-ones image; one out-of-range write too.
    for (int a = 0; a < 74; a++) begin
      exp_mem[a]   = (a < 10) ? 4'(a + 1) : 4'd1;
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 7'(a);
      bus.cfg_data = exp_mem[a];
      step();
    end
    bus.cfg_addr = 7'd100;
    bus.cfg_data = 4'h9;
    step();
    bus.cfg_we = 1'b0;
    check("idle_busy", 32'(bus.busy), 0);

    // Run 1: write attempt while busy, contiguous results.
    poke = 1'b1;
    stream(-1);
    poke = 1'b0;
    results(-1);

    // Start in the done cycle is dropped.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("post_done_busy", 32'(bus.busy),         0);
    check("no_relaunch_fv", 32'(bus.filter_valid), 0);
    check("post_done_done", 32'(bus.done),         0);

    // Run 2: next-cycle start, buffer unchanged, gapped results.
    stream(-1);
    results(5);
    step();
    check("run2_busy_after", 32'(bus.busy), 0);
    check("run2_done_after", 32'(bus.done), 0);

    // Run 3: async reset at image pixel 30, then restart with no reload.
    stream(40);
    #2 rst_n = 1'b0;
    #1 check_cleared("arst");
    #2 rst_n = 1'b1;
    step();
    for (int a = 0; a < 74; a++) exp_mem[a] = 4'd0;
    stream(-1);

`ifdef CONV_STREAM_TX_TIMEOUT_EN
    for (int s = 1; s <= 32; s++) begin
      step();
      if (s < 32) begin
        check($sformatf("to_err_%0d", s), 32'(bus.err), 0);
      end else begin
        check("to_err", 32'(bus.err),  1);
        check("to_busy", 32'(bus.busy), 0);
        check("to_done", 32'(bus.done), 0);
      end
    end
    step();
    check("to_err_pulse", 32'(bus.err),  0);
    check("to_busy_after", 32'(bus.busy), 0);
`else
    lost = 0;
    repeat (200) begin
      step();
      if (!bus.busy || bus.err) lost++;
    end
    check("wait_persist", 32'(lost), 0);
    check("wait_busy_200", 32'(bus.busy), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_stream_tx.md
CONV_STREAM_TX -- requirements
Module: conv_stream_tx

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: cfg_we  input  1  buffer write strobe; cfg_addr  input  7  0-9 filter taps, 10-73 image pixels; cfg_data  input  4  nibble to write.
REQ-004 SHALL have: start  input  1  one-cycle launch request.
REQ-005 SHALL have: filter_valid  output  1; image_valid  output  1; in_data  output  4; these form the serial stream to the convolution engine.
REQ-006 SHALL have: out_valid  input  1; out_data  input  16; these are the result stream from the convolution engine.
REQ-007 SHALL have: res_valid  output  1; res_idx  output  4; res_data  output  16; these carry the forwarded result, its index and its value.
REQ-008 SHALL have: busy  output  1; done  output  1  one-cycle pulse; err  output  1  one-cycle pulse.

Function
REQ-009 SHALL hold a 74-entry x 4-bit buffer; a write with cfg_we=1 and cfg_addr<=73 while busy=0 stores cfg_data; writes with addr>73 or busy=1 are ignored.
REQ-010 SHALL implement states IDLE, FILT, IMG, WAIT, COLL; busy=1 in every state except IDLE.
REQ-011 IDLE->FILT on start=1; start in any other state is ignored.
REQ-012 SHALL register all stream outputs; for start sampled at edge T, filter_valid=1 with in_data=buf[k] at cycles T+1+k, k=0..9.
REQ-013 FILT->IMG with no idle cycle; image_valid=1 with in_data=buf[10+k] at cycles T+11+k, k=0..63; filter_valid and image_valid SHALL never both be 1.
REQ-014 After the 64th pixel SHALL enter WAIT; in_data=0 whenever neither valid is asserted.
REQ-015 out_valid SHALL be ignored in IDLE, FILT and IMG.
REQ-016 In WAIT or COLL each cycle with out_valid=1 SHALL produce, one cycle later, res_valid=1, res_data=out_data, res_idx=result count (0..15), then increment the count; WAIT->COLL on the first result.
REQ-017 Cycles with out_valid=0 in COLL SHALL hold the count with res_valid=0; results need not be contiguous.
REQ-018 On the 16th result SHALL return to IDLE and pulse done=1 coincident with the res_idx=15 beat.
REQ-019 A start arriving in the same cycle as done SHALL be ignored; a new start SHALL be accepted from the following cycle.
REQ-020 Buffer contents SHALL persist across runs, so back-to-back runs need no reload.
REQ-021 res_data SHALL be passed unmodified at full 16-bit width, with no sign processing.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE and clear all counters and outputs: filter_valid=0, image_valid=0, in_data=0, res_valid=0, res_idx=0, res_data=0, busy=0, done=0, err=0.
REQ-023 Reset mid-run SHALL abort the run with no done pulse; buffer contents after reset SHALL be 0.

Configuration
REQ-024 Macro CONV_STREAM_TX_TIMEOUT_EN: when defined, WAIT SHALL count cycles without out_valid; on reaching 32 it SHALL pulse err=1 and return to IDLE with no done.
REQ-025 When CONV_STREAM_TX_TIMEOUT_EN is undefined, WAIT SHALL persist indefinitely and err SHALL be tied to 0.

Verification
REQ-026 Load filter=1..10 and image=all 1, start at cycle 5 -> filter_valid cycles 6-15 with in_data 1..10, image_valid cycles 16-79, busy=1 from cycle 6.
REQ-027 Return 16 contiguous out_valid beats with out_data=0x0100+i -> res_idx 0..15 with res_data 0x0100..0x010F one cycle later, done=1 with idx 15, busy=0 the next cycle.
REQ-028 Drop out_valid for 3 cycles after the 5th result -> res_valid gaps, count resumes at idx 5, done still after 16 results.
REQ-029 Pulse rst_n=0 during IMG at pixel 30 -> all outputs 0 immediately, no done; a subsequent start with no reload streams all-zero nibbles.
REQ-030 With CONV_STREAM_TX_TIMEOUT_EN defined and no out_valid after IMG -> err=1 exactly 32 cycles after WAIT entry, busy=0 afterwards; with the macro undefined, busy stays 1 for 200 cycles.
REQ-031 Assert cfg_we addr=3 data=0xF while busy, and start in the done cycle -> buffer unchanged and no relaunch; a start issued next cycle launches normally.
